// File: rtl/async_fifo_sc_pkg.sv
// Shared constants and pointer helpers for async_fifo_sc.
// Gray helpers work on a fixed maximum width. Callers zero-extend their pointer
// on the way in and truncate the result on the way out.
package async_fifo_sc_pkg;

    // Flops in each pointer synchronizer chain.
    localparam int SYNC_STAGES = 2;

    // Widest pointer the Gray helpers accept.
    localparam int GRAY_MAX_W = 32;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary; zero upper bits do not disturb the low bits.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sc_ptr_sync.sv
// Pointer transfer path between the two FIFO sides.
// The binary pointer is Gray-coded into a register. It then passes through
// SYNC_STAGES flops and is decoded back to binary. The result appears
// SYNC_STAGES+1 edges after the source pointer changes, which matches the
// dual-clock part.
module async_fifo_sc_ptr_sync
    import async_fifo_sc_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_bin
);

    logic [W-1:0]                  w_gray;
    logic [W-1:0]                  r_gray;
    logic [SYNC_STAGES-1:0][W-1:0] r_sync;

    assign w_gray = W'(bin2gray(GRAY_MAX_W'(i_bin)));

    // Register the Gray-coded pointer so only one bit changes per step into the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gray <= '0;
        end else begin
            r_gray <= w_gray;
        end
    end

    // Synchronizer chain; element 0 is the first stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], r_gray};
        end
    end

    assign o_bin = W'(gray2bin(GRAY_MAX_W'(r_sync[SYNC_STAGES-1])));

endmodule

// File: rtl/async_fifo_sc.sv
// Single-clock FIFO. It keeps the asynchronous-FIFO port set and pointer
// scheme, and its read side is first-word-fall-through.
// Optional feature macro: ASYNC_FIFO_SC_PTR_SYNC_EN. When it is defined, each
// pointer crosses to the opposite side through a Gray-coded 2-flop
// synchronizer, so flag latency matches a dual-clock FIFO.
module async_fifo_sc
    import async_fifo_sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_shift,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_full,
    output logic             in_nempty,
    input  logic             out_pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nempty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    w_wview;   // write pointer as seen by the read side
    logic [PW-1:0]    w_rview;   // read pointer as seen by the write side
    logic             w_wr;
    logic             w_rd;

`ifdef ASYNC_FIFO_SC_PTR_SYNC_EN
    async_fifo_sc_ptr_sync #(.W(PW)) u_wptr_sync (
        .clk   (clk),
        .rst   (rst),
        .i_bin (r_wptr),
        .o_bin (w_wview)
    );

    async_fifo_sc_ptr_sync #(.W(PW)) u_rptr_sync (
        .clk   (clk),
        .rst   (rst),
        .i_bin (r_rptr),
        .o_bin (w_rview)
    );
`else
    assign w_wview = r_wptr;
    assign w_rview = r_rptr;
`endif

    // Each side builds its flags from its own pointer and its view of the
    // other pointer. A stale view can only make a flag pessimistic.
    assign in_full    = (r_wptr == {~w_rview[AW], w_rview[AW-1:0]});
    assign in_nempty  = (r_wptr != w_rview);
    assign out_nempty = (w_wview != r_rptr);

    // Flags are evaluated before the edge, so a pop at full cannot admit a same-cycle shift.
    assign w_wr = in_shift && !in_full    && !rst;
    assign w_rd = out_pop  && out_nempty  && !rst;

    // Storage write. Contents are not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= in_data;
        end
    end

    // Write pointer; it advances only on an accepted shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_wr) begin
            r_wptr <= r_wptr + PTR_ONE;
        end else begin
            r_wptr <= r_wptr;
        end
    end

    // Read pointer; it advances only on an accepted pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr <= '0;
        end else if (w_rd) begin
            r_rptr <= r_rptr + PTR_ONE;
        end else begin
            r_rptr <= r_rptr;
        end
    end

    // The head word falls through combinationally from storage.
    assign out_data = r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_async_fifo_sc.sv
// Randomized self-checking bench for async_fifo_sc.
// The reference model is a queue plus running totals of accepted shifts and
// pops. Each side sees the other side's total as it stood VIEW_DLY edges
// earlier. VIEW_DLY is 3 when ASYNC_FIFO_SC_PTR_SYNC_EN is defined and 0 when
// it is not.
module tb_async_fifo_sc;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
`ifdef ASYNC_FIFO_SC_PTR_SYNC_EN
    localparam int VIEW_DLY = 3;
`else
    localparam int VIEW_DLY = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_shift = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_full;
    logic             in_nempty;
    logic             out_pop = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_nempty;

    async_fifo_sc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_shift   (in_shift),
        .in_data    (in_data),
        .in_full    (in_full),
        .in_nempty  (in_nempty),
        .out_pop    (out_pop),
        .out_data   (out_data),
        .out_nempty (out_nempty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_q [$];
    int               m_wtot;
    int               m_rtot;
    int               m_hw [4];   // m_hw[k]: shift total k edges ago
    int               m_hr [4];   // m_hr[k]: pop total k edges ago
    int               m_popped;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_full();
        return (m_wtot - m_hr[VIEW_DLY]) == DEPTH;
    endfunction

    function automatic bit m_in_nempty();
        return m_wtot != m_hr[VIEW_DLY];
    endfunction

    function automatic bit m_out_nempty();
        return m_hw[VIEW_DLY] != m_rtot;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_wtot = 0;
        m_rtot = 0;
        for (int k = 0; k < 4; k++) begin
            m_hw[k] = 0;
            m_hr[k] = 0;
        end
    endtask

    // One clock cycle. Outputs are checked at the negedge, inputs are driven,
    // and the model is advanced at the posedge.
    task automatic step(input logic r, input logic sh, input logic [WIDTH-1:0] d, input logic pp);
        logic [WIDTH-1:0] s_data;
        bit a_sh;
        bit a_pp;
        @(negedge clk);
        check_val("in_full",    32'(in_full),    32'(m_full()));
        check_val("in_nempty",  32'(in_nempty),  32'(m_in_nempty()));
        check_val("out_nempty", 32'(out_nempty), 32'(m_out_nempty()));
        if (m_out_nempty()) begin
            check_val("head", 32'(out_data), 32'(m_q[0]));
        end
        s_data   = out_data;
        rst      = r;
        in_shift = sh;
        in_data  = d;
        out_pop  = pp;
        a_sh = sh && !m_full();
        a_pp = pp && m_out_nempty();
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (a_pp) begin
                check_val("pop_data", 32'(s_data), 32'(m_q.pop_front()));
                m_rtot++;
                m_popped++;
            end
            if (a_sh) begin
                m_q.push_back(d);
                m_wtot++;
            end
            for (int k = 3; k > 0; k--) begin
                m_hw[k] = m_hw[k-1];
                m_hr[k] = m_hr[k-1];
            end
            m_hw[0] = m_wtot;
            m_hr[0] = m_rtot;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Pop until the model is empty, then let the delayed views settle.
    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_q.size() > 0; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        idle(VIEW_DLY + 1);
        check_val("drained", 32'(m_q.size()), 32'd0);
    endtask

    initial begin
        int wcnt;
        model_reset();
        m_popped = 0;

        // Initial reset; outputs are unknown until the first reset edge.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(2);

        // Pop while empty is a no-op.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(VIEW_DLY + 1);

        // Fill with 0x00..0x1F, try a 33rd shift, then pop everything back.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        idle(VIEW_DLY + 1);
        drain();

        // A single word falls through, then is popped.
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        idle(VIEW_DLY);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(VIEW_DLY + 1);

        // At full, pop and shift on the same edge: the pop wins and the shift is refused.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        idle(VIEW_DLY + 1);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        check_val("count_after_popshift", 32'(m_q.size()), 32'(DEPTH - 1));
        idle(VIEW_DLY + 1);
        step(1'b0, 1'b1, 8'h78, 1'b0);
        idle(1);
        drain();

        // A reset in mid-operation discards the contents.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        idle(VIEW_DLY + 2);

        // Random traffic over several pointer wraps; shifted data is a running counter.
        m_popped = 0;
        wcnt = 0;
        for (int i = 0; i < 6000 && m_popped < 240; i++) begin
            logic sh;
            logic pp;
            sh = ($urandom_range(2) == 0);
            pp = ($urandom_range(2) == 0);
            if (sh && !m_full()) begin
                step(1'b0, 1'b1, 8'(wcnt), pp);
                wcnt++;
            end else begin
                step(1'b0, sh, 8'(wcnt), pp);
            end
        end
        check_val("random_words_popped", 32'(m_popped >= 240), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
